// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH,
// count tells full from empty. A pop while empty or a push while full without a pop is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO
// drained over a valid/ready interface.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun,
  output logic                          frame_err
);

  localparam int unsigned C  = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(C / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(C - 1);

  if (C < 4) begin : g_c_check
    $error("uart_rx_fifo: CLK_FREQ / BAUD_RATE must be at least 4");
  end

  rx_state_e     state;
  logic [1:0]    sync;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic          push_q;
  logic          fifo_full;
  logic          fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic          par_bad;
`endif

  assign rxs = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], rx};
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt    <= '0;
            bitidx <= '0;
            state  <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bitidx <= bitidx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_bad <= ^{shreg, rxs};
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            if (rxs && !par_bad) begin
              push_q <= 1'b1;
              state  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= rxs ? IDLE : WAIT_HIGH;
            end
`else
            if (rxs) begin
              push_q <= 1'b1;
              state  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push lands one edge after the stop sample; overrun reports a drop in that same cycle.
  assign out_valid = ~fifo_empty;
  assign overrun   = push_q & fifo_full & ~(out_valid & out_ready);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shreg),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at C=16, FIFO_DEPTH=4 (8N1 build).
module tb_uart_rx_fifo;

  localparam int unsigned CLK_FREQ   = 1_600_000;
  localparam int unsigned BAUD_RATE  = 100_000;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          C          = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int ovr_cycles = 0;
  int ferr_cycles = 0;

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun)   ovr_cycles++;
    if (frame_err) ferr_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int t);
    if (t < C) return 1'b0;
    if (t < 9 * C) return d[(t - C) / C];
    return stop;
  endfunction

  // Called #1 after a posedge; the first following edge samples the start bit.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int stop_len,
                             input int limit);
    int total;
    total = 9 * C + stop_len;
    for (int t = 0; t < total && t < limit; t++) begin
      rx = frame_bit(d, stop, t);
      @(posedge clk); #1;
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    drive_frame(d, 1'b1, C, 1000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    @(negedge clk);
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check(name, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] exp_count;
    int         exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int base_ovr;
    int base_ferr;

    vecs[0] = '{8'h01, 3'd1, 0, 0};
    vecs[1] = '{8'h02, 3'd2, 0, 0};
    vecs[2] = '{8'h03, 3'd3, 0, 0};
    vecs[3] = '{8'h04, 3'd4, 0, 0};
    vecs[4] = '{8'h05, 3'd4, 1, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    check("rst count",     32'(count),     32'd0);
    check("rst overrun",   32'(overrun),   32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    idle(4);

    // Single frame: out_valid rises on edge k+155.
    lat = -1;
    fork
      send_frame(8'hA5);
      begin
        for (int n = 1; n <= 200; n++) begin
          @(posedge clk); #1;
          if (out_valid && lat < 0) lat = n - 1;
        end
      end
    join
    check("latency", 32'(lat), 32'd155);
    check("a5 count", 32'(count), 32'd1);
    pop_expect("a5 data", 8'hA5);
    @(negedge clk);
    check("a5 pop count", 32'(count), 32'd0);
    check("a5 pop valid", 32'(out_valid), 32'd0);
    idle(4);

    // Back-to-back frames, no pops; the fifth overflows.
    base_ovr  = ovr_cycles;
    base_ferr = ferr_cycles;
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data);
      check($sformatf("b2b%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("b2b%0d overrun", i), 32'(ovr_cycles - base_ovr), 32'(vecs[i].exp_ovr));
      check($sformatf("b2b%0d frame_err", i), 32'(ferr_cycles - base_ferr), 32'(vecs[i].exp_ferr));
    end
    for (int i = 0; i < 4; i++) pop_expect($sformatf("b2b pop%0d", i), 8'(i + 1));
    @(negedge clk);
    check("b2b drained", 32'(count), 32'd0);
    idle(4);

    // Start-bit glitch: four low cycles only.
    base_ferr = ferr_cycles;
    repeat (4) begin
      rx = 1'b0;
      @(posedge clk); #1;
    end
    rx = 1'b1;
    idle(40);
    check("glitch frame_err", 32'(ferr_cycles - base_ferr), 32'd0);
    check("glitch count", 32'(count), 32'd0);

    // Stop bit held low for 40 cycles, then a good frame.
    drive_frame(8'h3C, 1'b0, 40, 1000);
    idle(4);
    check("break frame_err", 32'(ferr_cycles - base_ferr), 32'd1);
    check("break count", 32'(count), 32'd0);
    send_frame(8'h7E);
    check("after break count", 32'(count), 32'd1);
    pop_expect("after break data", 8'h7E);
    idle(4);

    // Full FIFO, fifth push coincides with a pop.
    for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i));
    check("full count", 32'(count), 32'd4);
    idle(4);
    base_ovr = ovr_cycles;
    fork
      send_frame(8'h14);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        check("coinc head", 32'(out_data), 32'h10);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
      end
    join
    check("coinc overrun", 32'(ovr_cycles - base_ovr), 32'd0);
    check("coinc count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("coinc pop%0d", i), 8'(8'h11 + i));
    @(negedge clk);
    check("coinc drained", 32'(count), 32'd0);
    idle(4);

    // Reset in the middle of a frame with two bytes buffered.
    send_frame(8'h21);
    send_frame(8'h22);
    check("pre-reset count", 32'(count), 32'd2);
    drive_frame(8'h23, 1'b1, C, 60);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst out_data",  32'(out_data),  32'd0);
    check("mid rst count",     32'(count),     32'd0);
    check("mid rst overrun",   32'(overrun),   32'd0);
    check("mid rst frame_err", 32'(frame_err), 32'd0);
    idle(30);
    check("post rst idle count", 32'(count), 32'd0);
    send_frame(8'h55);
    check("post rst count", 32'(count), 32'd1);
    pop_expect("post rst data", 8'h55);
    @(negedge clk);
    check("post rst drained", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front-end for the board I/O path: oversamples the asynchronous `Rx` line, deframes 8-bit UART characters, and buffers them in a small synchronous FIFO. The CPU-side I/O controller in `riscv_top` drains it over a valid/ready interface. In simulation the testbench drives the serial line directly, with this block as the first stage behind the `Rx` pin.

## Interface
- `CLK_FREQ`, 100_000_000: core clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `C = CLK_FREQ / BAUD_RATE` (integer division); elaboration error if `C < 4`.
- `FIFO_DEPTH`, 8: entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial line; idles high.
- `out_data` out 8: FIFO head byte; valid only while `out_valid`.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer pops the head when `out_valid && out_ready`.
- `count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `frame_err` out 1: one-cycle pulse when a bad stop bit is sampled.

## Operation
- `rx` passes through a 2-flop synchronizer, both flops reset to 1. All decisions use the synchronized signal `rxs`.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP, WAIT_HIGH. The baud counter runs 0..C-1; the bit index runs 0..7.
- IDLE: `rxs==0` → START with the counter cleared.
- START: at counter == C/2-1, sample `rxs`:
  - 1 → glitch; return to IDLE, nothing reported.
  - 0 → DATA, counter cleared.
- DATA: sample every C cycles, shifting LSB-first into the shift register. After bit 7 → PARITY or STOP.
- STOP: sample after C cycles.
  - 1 → push the byte and return to IDLE.
  - 0 → pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs==1`, then IDLE. This handles break conditions without spurious bytes.
- Push when full:
  - Without a pop in the same cycle: byte dropped, `overrun` pulses, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, `count` unchanged, no overrun.
- Push and pop while empty: the pop is ignored (`out_valid` was 0) and the push lands.
- Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth. `count` disambiguates full/empty.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `count=0`, `overrun=0`, `frame_err=0`.
  - FSM in IDLE, synchronizer = 1.
  - Reset mid-frame abandons the frame and empties the FIFO. The next frame needs a fresh falling edge after reset deasserts.
- Latency: let edge k be the first `clk` edge that samples the `rx` pin low.
  - The stop-bit sample occurs at edge k + 2 + C/2 + 8C + C.
  - `out_valid` and `count` update on the following edge. For C=16 that is k+155.
- Pop: `out_data` shows the next entry and `count` decrements on the edge after the accepting cycle. Throughput is one pop per cycle.
- `overrun` and `frame_err` are high for exactly the one cycle after the stop sample.

## Configuration
- `UART_RX_PARITY_EN` defined: 8E1 framing. PARITY state samples a 9th bit C cycles after bit 7; STOP follows C later (stop sample shifts by +C). On even-parity mismatch the byte is discarded, `frame_err` pulses at the stop sample, and the FSM goes to WAIT_HIGH if the stop bit is 0, else IDLE.
- Undefined: 8N1 framing; no PARITY state; parity logic absent.

## Structure
- Package `uart_pkg`: FSM state enum and the `C` computation as a constant function.
- Sub-module `sync_fifo`: width/depth parameterized, with push/pop/full/empty/count. `uart_rx_fifo` holds the synchronizer, the FSM, the baud and bit counters, the shift register, and the error pulses.

## Test plan
All tests use CLK_FREQ=1_600_000, BAUD_RATE=100_000 (C=16) and FIFO_DEPTH=4.
- Single frame 0xA5 (8N1), `out_ready=0` → `out_valid` rises at k+155, `out_data=0xA5`, `count=1`; one pop → `count=0`, `out_valid=0`.
- Five back-to-back frames 0x01..0x05, no pops → `count=4`, `overrun` pulses once on frame 5; pops return 0x01..0x04 in order.
- `rx` low for 4 cycles only → no byte, no `frame_err`, FSM back in IDLE.
- Frame 0x3C with stop bit held 0 for 40 cycles → `frame_err` pulses once, `count` stays 0. A following good 0x7E is received.
- FIFO full; a 5th frame's push coincides with `out_ready=1` → no `overrun`, `count` stays 4, the last pop yields the new byte.
- `rst` asserted mid-DATA with 2 bytes buffered → all outputs at reset values next cycle; a later 0x55 is received cleanly.
